// File: rtl/display_pkg.sv
// Shared constants for the 7-segment path: code-bus width, glyph codes and
// the blink phase encoding used by the scanner.
package display_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CODE_G     = 4'hA;
  localparam logic [DIGIT_W-1:0] CODE_B     = 4'hB;
  localparam logic [DIGIT_W-1:0] CODE_U     = 4'hC;
  localparam logic [DIGIT_W-1:0] CODE_F     = 4'hD;
  localparam logic [DIGIT_W-1:0] CODE_S     = 4'hE;
  localparam logic [DIGIT_W-1:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } blink_phase_t;

  // Only a true numeric zero counts for leading-zero blanking; glyphs never do.
  function automatic logic is_zero_code(input logic [DIGIT_W-1:0] code);
    return (code == 4'h0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV counter with a single-cycle terminal-count flag,
// used as the per-digit slot timer of the display scanner.
module tick_gen #(
  parameter int DIV = 50000,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          tick
);

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexes a packed multi-digit code word onto the shared decoder bus with
// frame-synchronous loading, anode guard time, leading-zero blanking and blink.
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic                          update,
  input  logic                          lzb,
  input  logic                          blink,
  output logic [DIGIT_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_start,
  output logic                          pending
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int FC_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]                    count;
  logic                                 tick;
  logic [IDX_W-1:0]                     index;
  logic                                 boundary;
  logic                                 boundary_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   disp_reg;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   pend_reg;
  blink_phase_t                         phase, phase_nxt;
  logic [FC_W-1:0]                      frame_cnt, frame_cnt_nxt;
  logic [NUM_DIGITS-1:0]                blank;
  logic                                 zero_run;
  logic [DIGIT_W-1:0]                   code_nxt;
  logic [NUM_DIGITS-1:0]                an_nxt;

  tick_gen #(
    .DIV (REFRESH_DIV),
    .CW  (SLOT_W)
  ) u_slot (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tick  (tick)
  );

  assign boundary = tick && (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst)       index <= '0;
    else if (tick) index <= (index == LAST_IDX) ? '0 : index + 1'b1;
  end

  // The display register only changes at a frame boundary so a frame never
  // mixes old and new digits; an update on the boundary itself skips pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= {NUM_DIGITS{CODE_BLANK}};
      pend_reg <= {NUM_DIGITS{CODE_BLANK}};
      pending  <= 1'b0;
    end else if (boundary && update) begin
      disp_reg <= value;
      pending  <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end
      if (update) begin
        pend_reg <= value;
        pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    phase_nxt     = phase;
    frame_cnt_nxt = frame_cnt;
    if (!blink) begin
      phase_nxt     = PHASE_ON;
      frame_cnt_nxt = '0;
    end else if (boundary) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt_nxt = '0;
        phase_nxt     = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PHASE_ON;
      frame_cnt <= '0;
    end else begin
      phase     <= phase_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // A digit is blanked while every display digit from the top down to it is zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & is_zero_code(disp_reg[i]);
      blank[i] = lzb & zero_run;
    end
  end

  always_comb begin
    code_nxt = blank[index] ? CODE_BLANK : disp_reg[index];
    an_nxt   = '1;
    if ((count >= GUARD_END) && !(blink && (phase == PHASE_OFF)))
      an_nxt[index] = 1'b0;
  end

  // frame_start goes through two stages so it lines up with the first
  // registered output cycle of the new frame's digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= '1;
      digit_code  <= CODE_BLANK;
      boundary_d  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      digit_code  <= code_nxt;
      boundary_d  <= boundary;
      frame_start <= boundary_d;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: each scenario queues the expected
// per-cycle {frame_start, pending, an, digit_code} and a monitor compares.
module tb_display_scan;
  import display_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BF = 2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] value  = 16'h0000;
  logic        update = 1'b0;
  logic        lzb    = 1'b0;
  logic        blink  = 1'b0;
  logic [3:0]  digit_code;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cur_scen = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [7:0] scen;
    logic [7:0] frm;
    logic [7:0] off;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  display_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .update      (update),
    .lzb         (lzb),
    .blink       (blink),
    .digit_code  (digit_code),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] packExp(input logic fs, input logic pend,
                                         input logic [3:0] a, input logic [3:0] code);
    return {fs, pend, a, code};
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got {fs,pend,an,code}=%b want %b", name, act, exp);
    end
  endtask

  task automatic pushEntry(input int frm, input int off, input logic [9:0] exp);
    sb_t e;
    e.scen = 8'(cur_scen);
    e.frm  = 8'(frm);
    e.off  = 8'(off);
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // One output frame: codes holds the shown code per digit (digit 0 in [3:0]),
  // pending is expected high for offsets pset..pclr-1.
  task automatic pushFrame(input int frm, input logic [15:0] codes, input bit lit,
                           input bit fs, input int pset, input int pclr, input int ncyc = 32);
    for (int o = 0; o < ncyc; o++) begin
      int slot;
      int c;
      logic [3:0] a;
      slot = o / RD;
      c    = o % RD;
      a    = 4'b1111;
      if (lit && c >= GC) a[slot] = 1'b0;
      pushEntry(frm, o, packExp(fs && (o == 0), (o >= pset) && (o < pclr), a, codes[slot*4 +: 4]));
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic waitUntil(input int at);
    if (at > cyc) waitCycles(at - cyc);
  endtask

  task automatic applyStimulus(input int at, input logic [15:0] v);
    waitUntil(at);
    value  = v;
    update = 1'b1;
    waitCycles(1);
    update = 1'b0;
  endtask

  task automatic doReset(input int scen);
    rst    = 1'b1;
    update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("s%0d_rst_hold", scen), {frame_start, pending, an, digit_code},
                packExp(1'b0, 1'b0, 4'hF, 4'hF));
    rst      = 1'b0;
    cyc      = 0;
    cur_scen = scen;
    pushEntry(255, 0, packExp(1'b0, 1'b0, 4'hF, 4'hF));
    mon_en = 1'b1;
  endtask

  task automatic waitEmpty();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL s%0d_drain: got %0d entries left want 0", cur_scen, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: the outputs are presented every cycle, so one entry per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got an=%b code=%h want no further output", an, digit_code);
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("s%0d_f%0d_o%0d", mon_e.scen, mon_e.frm, mon_e.off),
                    {frame_start, pending, an, digit_code}, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle scan of a blank display.
    doReset(1);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 0, 0);
    pushFrame(1, 16'hFFFF, 1'b1, 1'b1, 0, 0);
    waitEmpty();

    // Mid-frame load waits for the boundary.
    doReset(2);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 10, 31);
    pushFrame(1, 16'h1234, 1'b1, 1'b1, 0, 0);
    pushFrame(2, 16'h1234, 1'b1, 1'b1, 0, 0);
    applyStimulus(10, 16'h1234);
    waitEmpty();

    // Last update wins; an update on the boundary tick loads directly.
    doReset(3);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 5, 31);
    pushFrame(1, 16'h2222, 1'b1, 1'b1, 0, 0);
    pushFrame(2, {CODE_F, CODE_U, 8'h78}, 1'b1, 1'b1, 0, 0);
    pushFrame(3, {CODE_F, CODE_U, 8'h78}, 1'b1, 1'b1, 0, 0);
    applyStimulus(5, 16'h1111);
    applyStimulus(20, 16'h2222);
    applyStimulus(63, {CODE_F, CODE_U, 8'h78});
    waitEmpty();

    // Leading-zero blanking.
    doReset(4);
    lzb = 1'b1;
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 2, 31);
    pushFrame(1, 16'hFF50, 1'b1, 1'b1, 8, 31);
    pushFrame(2, 16'hFFF0, 1'b1, 1'b1, 8, 31);
    pushFrame(3, {CODE_G, 12'h000}, 1'b1, 1'b1, 8, 31);
    pushFrame(4, {CODE_BLANK, CODE_G, 8'h05}, 1'b1, 1'b1, 0, 0);
    applyStimulus(2, 16'h0050);
    applyStimulus(40, 16'h0000);
    applyStimulus(72, {CODE_G, 12'h000});
    applyStimulus(104, {4'h0, CODE_G, 8'h05});
    waitEmpty();
    lzb = 1'b0;

    // Blink: two frames lit, two dark, repeat; dropping blink relights at once.
    doReset(5);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 2, 31);
    pushFrame(1, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b1, 1'b1, 0, 0);
    pushFrame(2, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b1, 1'b1, 0, 0);
    pushFrame(3, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b0, 1'b1, 0, 0);
    pushFrame(4, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b0, 1'b1, 0, 0);
    pushFrame(5, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b1, 1'b1, 0, 0);
    pushFrame(6, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b1, 1'b1, 0, 0);
    pushFrame(7, {4'h9, CODE_S, CODE_B, 4'h0}, 1'b1, 1'b1, 0, 0);
    applyStimulus(2, {4'h9, CODE_S, CODE_B, 4'h0});
    waitUntil(32);
    blink = 1'b1;
    waitUntil(224);
    blink = 1'b0;
    waitEmpty();

    // Reset while a value is pending discards it.
    doReset(6);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 10, 31, 20);
    pushEntry(0, 20, packExp(1'b0, 1'b0, 4'hF, 4'hF));
    applyStimulus(10, 16'h4321);
    waitUntil(20);
    rst = 1'b1;
    waitEmpty();
    doReset(6);
    pushFrame(0, 16'hFFFF, 1'b1, 1'b0, 0, 0);
    pushFrame(1, 16'hFFFF, 1'b1, 1'b1, 0, 0);
    waitEmpty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
